// File: rtl/unidade_busca.sv
// Instruction-fetch / program-counter stage: sequences the PC (increment, jump, branch, stall),
// parks on HALT, restarts on the selector's pulse and counts retired instructions.
module unidade_busca #(
  parameter int                     LARGURA_END      = 10,
  parameter logic [LARGURA_END-1:0] ENDERECO_INICIAL = '0,
  parameter logic [5:0]             OPCODE_HALT      = 6'b011000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   reinicio_pc,
  input  logic [31:0]            instrucao,
  input  logic                   espera,
  input  logic                   salto,
  input  logic [LARGURA_END-1:0] alvo_salto,
  input  logic                   desvio,
  input  logic [LARGURA_END-1:0] alvo_desvio,
  input  logic                   continuar,
  output logic [LARGURA_END-1:0] endereco,
  output logic [LARGURA_END-1:0] pc_mais_um,
  output logic                   parado,
  output logic [31:0]            instrucoes_exec
);

  typedef enum logic [0:0] {
    BUSCA  = 1'b0,
    PARADO = 1'b1
  } estado_t;

  localparam logic [LARGURA_END-1:0] UM_END   = {{(LARGURA_END-1){1'b0}}, 1'b1};
  localparam logic [31:0]            CONT_MAX = 32'hFFFF_FFFF;

  estado_t                estado_q, estado_d;
  logic [LARGURA_END-1:0] endereco_q, endereco_d;
  logic                   parado_q, parado_d;
  logic [31:0]            contador_q, contador_d;
  logic                   retira_s;
  logic                   eh_halt_s;

  assign pc_mais_um      = endereco_q + UM_END;
  assign eh_halt_s       = (instrucao[31:26] == OPCODE_HALT);
  assign endereco        = endereco_q;
  assign parado          = parado_q;
  assign instrucoes_exec = contador_q;

  // Next-state, next-PC and retire decision
  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    retira_s   = 1'b0;
    case (estado_q)
      BUSCA: begin
        if (reinicio_pc) begin
          endereco_d = ENDERECO_INICIAL;
        end else if (espera) begin
          endereco_d = endereco_q;
        end else if (eh_halt_s) begin
          // HALT retires but the PC stays on it, so the word is not refetched past
          estado_d = PARADO;
          retira_s = 1'b1;
        end else if (salto) begin
          endereco_d = alvo_salto;
          retira_s   = 1'b1;
        end else if (desvio) begin
          endereco_d = alvo_desvio;
          retira_s   = 1'b1;
        end else begin
          endereco_d = pc_mais_um;
          retira_s   = 1'b1;
        end
      end
      PARADO: begin
        if (reinicio_pc) begin
          endereco_d = ENDERECO_INICIAL;
          estado_d   = BUSCA;
        end else if (continuar) begin
          endereco_d = pc_mais_um;
          estado_d   = BUSCA;
        end else begin
          estado_d = PARADO;
        end
      end
      default: begin
        estado_d   = BUSCA;
        endereco_d = ENDERECO_INICIAL;
      end
    endcase
  end

  // Saturating retire counter and registered halt flag
  always_comb begin
    contador_d = contador_q;
    parado_d   = (estado_d == PARADO);
    if (retira_s && (contador_q != CONT_MAX)) begin
      contador_d = contador_q + 32'd1;
    end else begin
      contador_d = contador_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= BUSCA;
      endereco_q <= ENDERECO_INICIAL;
      parado_q   <= 1'b0;
      contador_q <= 32'd0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      parado_q   <= parado_d;
      contador_q <= contador_d;
    end
  end

endmodule

// File: tb/tb_unidade_busca.sv
// Directed + randomized bench for unidade_busca, checked against a behavioural PC/counter model.
module tb_unidade_busca;

  localparam int         W    = 10;
  localparam int         MODW = 1 << W;
  localparam logic [5:0] HALT = 6'b011000;

  logic          clock = 1'b0;
  logic          reset, reinicio_pc, espera, salto, desvio, continuar;
  logic [31:0]   instrucao;
  logic [W-1:0]  alvo_salto, alvo_desvio;
  logic [W-1:0]  endereco, pc_mais_um;
  logic          parado;
  logic [31:0]   instrucoes_exec;

  int checks   = 0;
  int failures = 0;

  int      m_pc;
  bit      m_halted;
  longint  m_cnt;

  unidade_busca #(.LARGURA_END(W), .ENDERECO_INICIAL(10'd0), .OPCODE_HALT(HALT)) dut (
    .clock(clock), .reset(reset), .reinicio_pc(reinicio_pc), .instrucao(instrucao),
    .espera(espera), .salto(salto), .alvo_salto(alvo_salto), .desvio(desvio),
    .alvo_desvio(alvo_desvio), .continuar(continuar), .endereco(endereco),
    .pc_mais_um(pc_mais_um), .parado(parado), .instrucoes_exec(instrucoes_exec)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] nop_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == HALT) w[26] = ~w[26];
    return w;
  endfunction

  function automatic logic [31:0] halt_word();
    logic [31:0] w;
    w = $urandom;
    w[31:26] = HALT;
    return w;
  endfunction

  task automatic drive(input bit rst, input bit rei, input logic [31:0] ins, input bit esp,
                       input bit sal, input int as, input bit des, input int ad, input bit cont);
    reset = rst; reinicio_pc = rei; instrucao = ins; espera = esp;
    salto = sal; alvo_salto = W'(as); desvio = des; alvo_desvio = W'(ad); continuar = cont;
  endtask

  // Applies the fetch-unit rules to the model from the inputs currently driven.
  task automatic model_step();
    if (reset) begin
      m_pc = 0; m_halted = 0; m_cnt = 0;
    end else if (!m_halted) begin
      if (reinicio_pc) m_pc = 0;
      else if (espera) ;
      else begin
        if (instrucao[31:26] == HALT) m_halted = 1;
        else if (salto) m_pc = int'(alvo_salto);
        else if (desvio) m_pc = int'(alvo_desvio);
        else m_pc = (m_pc + 1) % MODW;
        if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
    end else begin
      if (reinicio_pc) begin m_pc = 0; m_halted = 0; end
      else if (continuar) begin m_pc = (m_pc + 1) % MODW; m_halted = 0; end
    end
  endtask

  task automatic tick();
    chk("pc_mais_um", 32'(pc_mais_um), 32'((m_pc + 1) % MODW));
    model_step();
    @(posedge clock);
    #1;
    chk("endereco", 32'(endereco), 32'(m_pc));
    chk("parado", 32'(parado), 32'(m_halted));
    chk("instrucoes_exec", instrucoes_exec, m_cnt[31:0]);
    @(negedge clock);
  endtask

  initial begin
    m_pc = 0; m_halted = 0; m_cnt = 0;
    drive(1, 0, nop_word(), 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    // T1: reset held 2 cycles
    tick(); tick();
    chk("t1_endereco", 32'(endereco), 32'd0);
    chk("t1_parado", 32'(parado), 32'd0);
    chk("t1_count", instrucoes_exec, 32'd0);
    // T2: three NOPs
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, nop_word(), 0, 0, 0, 0, 0, 0);
      tick();
      chk("t2_endereco", 32'(endereco), 32'(i + 1));
    end
    chk("t2_count", instrucoes_exec, 32'd3);
    // T3: HALT at 5, then restart pulse
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, nop_word(), 0, 0, 0, 0, 0, 0);
      tick();
    end
    chk("t3_at5", 32'(endereco), 32'd5);
    drive(0, 0, halt_word(), 0, 0, 0, 0, 0, 0);
    tick();
    chk("t3_halt_end", 32'(endereco), 32'd5);
    chk("t3_halt_parado", 32'(parado), 32'd1);
    drive(0, 1, halt_word(), 0, 1, 'h55, 0, 0, 0);
    tick();
    chk("t3_restart_end", 32'(endereco), 32'd0);
    chk("t3_restart_parado", 32'(parado), 32'd0);
    chk("t3_count", instrucoes_exec, 32'd6);
    // T4: salto beats desvio; espera holds everything
    drive(0, 0, nop_word(), 0, 1, 'h020, 1, 'h030, 0);
    tick();
    chk("t4_salto", 32'(endereco), 32'h020);
    drive(0, 0, nop_word(), 1, 1, 'h100, 1, 'h030, 0);
    tick();
    chk("t4_espera_end", 32'(endereco), 32'h020);
    chk("t4_espera_cnt", instrucoes_exec, 32'd7);
    // T5: wrap-around from 0x3FF
    drive(0, 0, nop_word(), 0, 1, 'h3FF, 0, 0, 0);
    tick();
    drive(0, 0, nop_word(), 0, 0, 0, 0, 0, 0);
    chk("t5_pc_mais_um", 32'(pc_mais_um), 32'd0);
    tick();
    chk("t5_wrap", 32'(endereco), 32'd0);
    // T6: PARADO at 7 with continuar, continuar+reinicio, reset
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, nop_word(), 0, 1, 7, 0, 0, 0);
      tick();
      drive(0, 0, halt_word(), 0, 0, 0, 0, 0, 0);
      tick();
      chk("t6_parked", 32'(parado), 32'd1);
      drive(0, 0, nop_word(), 1, 1, 'h1AB, 1, 'h1CD, 0);
      tick();
      chk("t6_ignored", 32'(endereco), 32'd7);
      if (k == 0) begin
        drive(0, 0, nop_word(), 0, 0, 0, 0, 0, 1);
        tick();
        chk("t6_continuar", 32'(endereco), 32'd8);
        chk("t6_continuar_parado", 32'(parado), 32'd0);
      end else if (k == 1) begin
        drive(0, 1, nop_word(), 0, 0, 0, 0, 0, 1);
        tick();
        chk("t6_reinicio_wins", 32'(endereco), 32'd0);
      end else begin
        drive(1, 0, nop_word(), 0, 0, 0, 0, 0, 1);
        tick();
        chk("t6_reset_end", 32'(endereco), 32'd0);
        chk("t6_reset_cnt", instrucoes_exec, 32'd0);
      end
    end
    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5),
            (r < 12) ? halt_word() : nop_word(),
            ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 15), int'($urandom_range(0, MODW - 1)),
            ($urandom_range(0, 99) < 15), int'($urandom_range(0, MODW - 1)),
            ($urandom_range(0, 99) < 30));
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
